// File: rtl/z80_io_reader.sv
// z80_io_reader
//   Answers Z80 IN cycles on the VRAM port block. The two pointer ports read
//   back the VRAM address pointer. The value port stretches the cycle with
//   WAIT, fetches the word at the pointer from SDRAM and drives its low byte,
//   then post-increments the pointer. Z80 OUT cycles to the pointer ports are
//   snooped so that vram_ptr follows the CPU. Runs in the 64 MHz SDRAM domain.
//
// Ports
//   clk, reset        : SDRAM clock, synchronous active-high reset
//   A, D_IN           : Z80 address low byte / data bus (asynchronous)
//   IORQ, RD, WR, M1  : Z80 strobes, active low (asynchronous)
//   D_OUT             : byte driven onto the Z80 data bus
//   OUTPUT_ENABLE     : data bus driver enable, active high
//   WAIT              : Z80 WAIT, active low
//   mem_req, mem_addr : level read request to the SDRAM arbiter, word address
//   mem_ack, mem_data : one-cycle acknowledge with read data
//   vram_ptr          : current VRAM pointer (shared with the write path)
//   timeout_err       : sticky, set when the arbiter never answered in time
module z80_io_reader #(
    parameter logic [7:0] ADDR_IO_ADDR_LOW  = 8'h40,
    parameter logic [7:0] ADDR_IO_ADDR_HIGH = 8'h41,
    parameter logic [7:0] VALUE_IO_ADDR     = 8'h42,
    parameter int         TIMEOUT           = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        OUTPUT_ENABLE,
    input  logic        IORQ,
    input  logic        RD,
    input  logic        WR,
    input  logic        M1,
    output logic        WAIT,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] vram_ptr,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [7:0]  a_s1, a_s2, d_s1, d_s2;
    logic        iorq_s1, iorq_s2, iorq_s3;
    logic        rd_s1, rd_s2, rd_s3;
    logic        wr_s1, wr_s2, wr_s3;
    logic        m1_s1, m1_s2;
    logic [7:0]  cnt;
    logic        inc;        // pointer increments when the current HOLD ends
    logic        ack_owed;   // timed-out request still outstanding at the arbiter
    logic        pend;       // read arrived during DRAIN, CPU parked in WAIT
    logic [7:0]  pend_port;

    // Synchroniser flops carry no reset: they only follow the pins, and
    // resetting them could fabricate a strobe edge if the CPU is mid-cycle.
    always_ff @(posedge clk) begin
        a_s1    <= A;      a_s2    <= a_s1;
        d_s1    <= D_IN;   d_s2    <= d_s1;
        iorq_s1 <= IORQ;   iorq_s2 <= iorq_s1; iorq_s3 <= iorq_s2;
        rd_s1   <= RD;     rd_s2   <= rd_s1;   rd_s3   <= rd_s2;
        wr_s1   <= WR;     wr_s2   <= wr_s1;   wr_s3   <= wr_s2;
        m1_s1   <= M1;     m1_s2   <= m1_s1;
    end

    logic       port_ok, start, go, cnt_hit, ptr_wr;
    logic [7:0] go_port;

    assign port_ok = (a_s2 == ADDR_IO_ADDR_LOW) || (a_s2 == ADDR_IO_ADDR_HIGH) ||
                     (a_s2 == VALUE_IO_ADDR);
    // M1 high at stage 2 keeps interrupt-acknowledge cycles out.
    assign start   = rd_s3 && !rd_s2 && !iorq_s2 && m1_s2 && port_ok;
    // A read parked during DRAIN is replayed from IDLE if RD is still low.
    assign go      = (state == IDLE) && (start || (pend && !rd_s2));
    assign go_port = pend ? pend_port : a_s2;
    assign cnt_hit = (cnt == TO_CNT);
    assign ptr_wr  = !wr_s3 && wr_s2 && !iorq_s3 &&
                     ((a_s2 == ADDR_IO_ADDR_LOW) || (a_s2 == ADDR_IO_ADDR_HIGH));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (go) state_n = (go_port == VALUE_IO_ADDR) ? FETCH : HOLD;
            FETCH: begin
                if (mem_ack)      state_n = HOLD;
                else if (rd_s2)   state_n = DRAIN;
                else if (cnt_hit) state_n = HOLD;
            end
            HOLD:  if (rd_s2) state_n = (ack_owed && !mem_ack) ? DRAIN : IDLE;
            DRAIN: if (mem_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs derived from state
    always_comb begin
        OUTPUT_ENABLE = (state == HOLD);
        WAIT          = !((state == FETCH) || pend);
        mem_req       = (state == FETCH) || (state == DRAIN) || ((state == HOLD) && ack_owed);
    end

    // Registered datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            D_OUT       <= 8'h00;
            mem_addr    <= 16'h0000;
            vram_ptr    <= 16'h0000;
            timeout_err <= 1'b0;
            cnt         <= 8'h00;
            inc         <= 1'b0;
            ack_owed    <= 1'b0;
            pend        <= 1'b0;
            pend_port   <= 8'h00;
        end else begin
            cnt <= (state == FETCH) ? cnt + 8'd1 : 8'h00;
            if (rd_s2) pend <= 1'b0;

            unique case (state)
                IDLE: if (go) begin
                    pend <= 1'b0;
                    if (go_port == ADDR_IO_ADDR_LOW)       D_OUT    <= vram_ptr[7:0];
                    else if (go_port == ADDR_IO_ADDR_HIGH) D_OUT    <= vram_ptr[15:8];
                    else                                   mem_addr <= vram_ptr;
                end
                FETCH: begin
                    if (mem_ack) begin
                        D_OUT <= mem_data[7:0];
                        inc   <= 1'b1;
                    end else if (!rd_s2 && cnt_hit) begin
                        D_OUT       <= 8'hFF;
                        timeout_err <= 1'b1;
                        ack_owed    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (mem_ack) ack_owed <= 1'b0;
                    if (rd_s2) begin
                        if (inc) vram_ptr <= vram_ptr + 16'd1;
                        inc      <= 1'b0;
                        ack_owed <= 1'b0;
                    end
                end
                DRAIN: if (start) begin
                    pend      <= 1'b1;
                    pend_port <= a_s2;
                end
                default: ;
            endcase

            // Pointer writes win over a same-cycle increment.
            if (ptr_wr) begin
                if (a_s2 == ADDR_IO_ADDR_LOW) vram_ptr[7:0]  <= d_s2;
                else                          vram_ptr[15:8] <= d_s2;
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_z80_io_reader.sv
module tb_z80_io_reader;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  A = 8'h00, D_IN = 8'h00;
    logic        IORQ = 1'b1, RD = 1'b1, WR = 1'b1, M1 = 1'b1;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [7:0]  D_OUT;
    logic        OUTPUT_ENABLE, WAIT, mem_req, timeout_err;
    logic [15:0] mem_addr, vram_ptr;

    z80_io_reader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .A(A), .D_IN(D_IN), .D_OUT(D_OUT),
        .OUTPUT_ENABLE(OUTPUT_ENABLE), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1),
        .WAIT(WAIT), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .vram_ptr(vram_ptr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [15:0] ptr_m = 16'h0000;   // reference pointer
    logic        err_m = 1'b0;       // reference sticky timeout flag
    bit          oe_seen, wait_seen, req_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled on the falling edge, inputs change after.
    task automatic tick();
        @(negedge clk);
        if (OUTPUT_ENABLE) oe_seen = 1'b1;
        if (!WAIT)         wait_seen = 1'b1;
        if (mem_req)       req_seen = 1'b1;
    endtask

    task automatic clr_seen();
        oe_seen = 1'b0; wait_seen = 1'b0; req_seen = 1'b0;
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] data);
        A = port; D_IN = data; M1 = 1'b1; IORQ = 1'b0; WR = 1'b0;
        repeat (4) tick();
        WR = 1'b1; IORQ = 1'b1;
        repeat (3) tick();
        if (port == 8'h40) begin ptr_m[7:0]  = data; err_m = 1'b0; end
        if (port == 8'h41) begin ptr_m[15:8] = data; err_m = 1'b0; end
        chk("ptr_after_out", vram_ptr, ptr_m);
        chk("err_after_out", timeout_err, err_m);
    endtask

    task automatic end_cycle();
        RD = 1'b1; IORQ = 1'b1;
        repeat (3) tick();
    endtask

    task automatic io_in_ptr(input logic [7:0] port);
        clr_seen();
        A = port; M1 = 1'b1; IORQ = 1'b0; RD = 1'b0;
        repeat (3) tick();
        chk("ptr_rd_oe", OUTPUT_ENABLE, 1'b1);
        chk("ptr_rd_dout", D_OUT, (port == 8'h40) ? ptr_m[7:0] : ptr_m[15:8]);
        repeat (2) tick();
        RD = 1'b1; IORQ = 1'b1;
        repeat (2) tick();
        chk("ptr_rd_oe_hold", OUTPUT_ENABLE, 1'b1);
        tick();
        chk("ptr_rd_oe_off", OUTPUT_ENABLE, 1'b0);
        chk("ptr_rd_no_wait", wait_seen, 1'b0);
    endtask

    task automatic io_in_val(input int delay, input logic [15:0] data);
        clr_seen();
        A = 8'h42; M1 = 1'b1; IORQ = 1'b0; RD = 1'b0;
        repeat (2) tick();
        chk("val_wait_pre", WAIT, 1'b1);
        tick();
        chk("val_wait_low", WAIT, 1'b0);
        chk("val_req", mem_req, 1'b1);
        chk("val_addr", mem_addr, ptr_m);
        repeat (delay) tick();
        chk("val_wait_held", WAIT, 1'b0);
        mem_data = data; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mem_data = 16'($urandom);
        chk("val_wait_rel", WAIT, 1'b1);
        chk("val_dout", D_OUT, data[7:0]);
        chk("val_req_off", mem_req, 1'b0);
        chk("val_oe", OUTPUT_ENABLE, 1'b1);
        chk("val_ptr_hold", vram_ptr, ptr_m);
        end_cycle();
        ptr_m = ptr_m + 16'd1;
        chk("val_ptr_inc", vram_ptr, ptr_m);
        chk("val_oe_off", OUTPUT_ENABLE, 1'b0);
    endtask

    initial begin
        int          n;
        logic [15:0] r, w;

        // Reset state
        repeat (5) tick();
        chk("rst_dout", D_OUT, 8'h00);
        chk("rst_oe", OUTPUT_ENABLE, 1'b0);
        chk("rst_wait", WAIT, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_ptr", vram_ptr, 16'h0000);
        chk("rst_err", timeout_err, 1'b0);
        reset = 1'b0;
        tick();

        // Pointer write and read back
        io_out(8'h40, 8'h34);
        io_out(8'h41, 8'h12);
        io_in_ptr(8'h40);
        io_in_ptr(8'h41);

        // Value read, ack after 10 cycles
        io_in_val(10, 16'hABCD);
        chk("ptr_1235", vram_ptr, 16'h1235);

        // Wrap at 0xFFFF
        io_out(8'h40, 8'hFF);
        io_out(8'h41, 8'hFF);
        io_in_val(3, 16'h5A77);
        chk("ptr_wrap", vram_ptr, 16'h0000);

        // Randomized pointer and data traffic
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            io_out(8'h40, w[7:0]);
            io_out(8'h41, w[15:8]);
            io_in_ptr(($urandom_range(0, 1) == 0) ? 8'h40 : 8'h41);
            for (int k = 0; k < 2; k++) begin
                r = 16'($urandom);
                io_in_val(int'($urandom_range(0, 20)), r);
            end
            io_in_ptr(8'h40);
            io_in_ptr(8'h41);
        end

        // Timeout: no ack, WAIT released after TIMEOUT cycles with 0xFF
        clr_seen();
        A = 8'h42; IORQ = 1'b0; RD = 1'b0;
        repeat (3) tick();
        chk("to_wait_low", WAIT, 1'b0);
        n = 0;
        while (!WAIT && n < 300) begin tick(); n++; end
        chk("to_window", (n >= TIMEOUT && n <= TIMEOUT + 2), 1'b1);
        err_m = 1'b1;
        chk("to_dout", D_OUT, 8'hFF);
        chk("to_err", timeout_err, err_m);
        chk("to_req_owed", mem_req, 1'b1);
        chk("to_oe", OUTPUT_ENABLE, 1'b1);
        end_cycle();
        chk("to_oe_off", OUTPUT_ENABLE, 1'b0);
        chk("to_ptr_same", vram_ptr, ptr_m);
        chk("to_drain_req", mem_req, 1'b1);
        // Read during DRAIN waits for the late ack
        A = 8'h40; IORQ = 1'b0; RD = 1'b0;
        repeat (3) tick();
        chk("drain_wait", WAIT, 1'b0);
        chk("drain_no_oe", OUTPUT_ENABLE, 1'b0);
        mem_data = 16'h1111; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("drain_rd_oe", OUTPUT_ENABLE, 1'b1);
        chk("drain_rd_wait", WAIT, 1'b1);
        chk("drain_rd_dout", D_OUT, ptr_m[7:0]);
        chk("drain_req_off", mem_req, 1'b0);
        end_cycle();
        io_out(8'h40, 8'h77);

        // Abort: RD released before ack
        clr_seen();
        A = 8'h42; IORQ = 1'b0; RD = 1'b0;
        repeat (3) tick();
        chk("ab_wait_low", WAIT, 1'b0);
        repeat (4) tick();
        end_cycle();
        chk("ab_wait_rel", WAIT, 1'b1);
        chk("ab_drain_req", mem_req, 1'b1);
        mem_data = 16'h2222; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("ab_req_off", mem_req, 1'b0);
        chk("ab_ptr_same", vram_ptr, ptr_m);
        chk("ab_no_oe", oe_seen, 1'b0);

        // Reset during a second FETCH
        A = 8'h42; IORQ = 1'b0; RD = 1'b0;
        repeat (3) tick();
        chk("rf_wait_low", WAIT, 1'b0);
        reset = 1'b1;
        tick();
        ptr_m = 16'h0000; err_m = 1'b0;
        chk("rf_dout", D_OUT, 8'h00);
        chk("rf_oe", OUTPUT_ENABLE, 1'b0);
        chk("rf_wait", WAIT, 1'b1);
        chk("rf_req", mem_req, 1'b0);
        chk("rf_addr", mem_addr, 16'h0000);
        chk("rf_ptr", vram_ptr, ptr_m);
        chk("rf_err", timeout_err, err_m);
        chk("rf_no_oe", oe_seen, 1'b0);
        reset = 1'b0;
        end_cycle();

        // Interrupt acknowledge addressed to the value port, and a foreign port
        clr_seen();
        A = 8'h42; M1 = 1'b0; IORQ = 1'b0; RD = 1'b0;
        repeat (6) tick();
        M1 = 1'b1;
        end_cycle();
        A = 8'h43; IORQ = 1'b0; RD = 1'b0;
        repeat (6) tick();
        end_cycle();
        chk("ign_req", req_seen, 1'b0);
        chk("ign_oe", oe_seen, 1'b0);
        chk("ign_wait", wait_seen, 1'b0);
        chk("ign_ptr", vram_ptr, ptr_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
